// File: rtl/seq_mag_comparator_pkg.sv
// Shared types for the sequential magnitude comparator: FSM state encoding
// and the one-hot {greater, equal, less} result codes.
package seq_mag_comparator_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Result flags packed as {A_greater, A_equal, A_less}
  localparam logic [2:0] RES_NONE = 3'b000;
  localparam logic [2:0] RES_GT   = 3'b100;
  localparam logic [2:0] RES_EQ   = 3'b010;
  localparam logic [2:0] RES_LT   = 3'b001;

endpackage

// File: rtl/seq_mag_comparator_chunk_cmp.sv
// Combinational CHUNK-wide magnitude compare; is_signed selects two's-complement
// ordering by inverting the sign bits before an unsigned compare.
module chunk_cmp #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             is_signed,
  output logic             gt,
  output logic             eq,
  output logic             lt
);

  logic [CHUNK-1:0] a_s;
  logic [CHUNK-1:0] b_s;

  // Bias the operands into unsigned order, then compare
  always_comb begin
    a_s = a;
    b_s = b;
    if (is_signed) begin
      a_s[CHUNK-1] = ~a[CHUNK-1];
      b_s[CHUNK-1] = ~b[CHUNK-1];
    end else begin
      a_s = a;
      b_s = b;
    end
    gt = (a_s > b_s);
    eq = (a_s == b_s);
    lt = (a_s < b_s);
  end

endmodule

// File: rtl/seq_mag_comparator.sv
// Compares two WIDTH-bit operands CHUNK bits per cycle from the MSB down,
// exiting early on the first differing chunk; valid/ready on both sides.
module seq_mag_comparator
  import seq_mag_comparator_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [WIDTH-1:0]                    A,
  input  logic [WIDTH-1:0]                    B,
  input  logic                                signed_mode,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic                                A_greater,
  output logic                                A_equal,
  output logic                                A_less,
  output logic [$clog2(WIDTH/((CHUNK < 1) ? 1 : CHUNK)+1)-1:0] chunks_used
);

  localparam int CHUNK_SAFE = (CHUNK < 1) ? 1 : CHUNK;
  localparam int NCHUNK     = WIDTH / CHUNK_SAFE;
  localparam int CNT_W      = $clog2(NCHUNK + 1);
  localparam int IDX_W      = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  generate
    if ((CHUNK < 1) || ((WIDTH % CHUNK_SAFE) != 0)) begin : g_bad_cfg
      $error("seq_mag_comparator: WIDTH must be a non-zero multiple of CHUNK >= 1");
    end
  endgenerate

  state_e                 state_r;
  state_e                 state_s;
  logic [WIDTH-1:0]       a_r;
  logic [WIDTH-1:0]       b_r;
  logic                   signed_r;
  logic [IDX_W-1:0]       idx_r;
  logic [CNT_W-1:0]       cnt_r;
  logic [2:0]             res_r;
  logic [CHUNK_SAFE-1:0]  chunk_a_s;
  logic [CHUNK_SAFE-1:0]  chunk_b_s;
  logic                   top_signed_s;
  logic                   gt_s;
  logic                   eq_s;
  logic                   lt_s;
  logic                   last_s;

  assign chunk_a_s    = a_r[idx_r*CHUNK_SAFE +: CHUNK_SAFE];
  assign chunk_b_s    = b_r[idx_r*CHUNK_SAFE +: CHUNK_SAFE];
  assign top_signed_s = signed_r && (idx_r == IDX_W'(NCHUNK - 1));
  assign last_s       = (idx_r == {IDX_W{1'b0}});

  chunk_cmp #(.CHUNK(CHUNK_SAFE)) u_chunk_cmp (
    .a         (chunk_a_s),
    .b         (chunk_b_s),
    .is_signed (top_signed_s),
    .gt        (gt_s),
    .eq        (eq_s),
    .lt        (lt_s)
  );

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:    if (in_valid) state_s = CMP; else state_s = IDLE;
      CMP:     if (!eq_s || last_s) state_s = DONE; else state_s = CMP;
      DONE:    if (out_ready) state_s = IDLE; else state_s = DONE;
      default: state_s = IDLE;
    endcase
  end

  // Operand capture, chunk walk and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r      <= {WIDTH{1'b0}};
      b_r      <= {WIDTH{1'b0}};
      signed_r <= 1'b0;
      idx_r    <= {IDX_W{1'b0}};
      cnt_r    <= {CNT_W{1'b0}};
      res_r    <= RES_NONE;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            a_r      <= A;
            b_r      <= B;
            signed_r <= signed_mode;
            idx_r    <= IDX_W'(NCHUNK - 1);
            cnt_r    <= {CNT_W{1'b0}};
            res_r    <= RES_NONE;
          end
        end
        CMP: begin
          cnt_r <= cnt_r + CNT_W'(1);
          if (gt_s) begin
            res_r <= RES_GT;
          end else if (lt_s) begin
            res_r <= RES_LT;
          end else if (last_s) begin
            res_r <= RES_EQ;
          end else begin
            idx_r <= idx_r - IDX_W'(1);
          end
        end
        DONE: begin
          // Flags must read zero again once the result has been taken
          if (out_ready) res_r <= RES_NONE;
        end
        default: res_r <= RES_NONE;
      endcase
    end
  end

  assign in_ready                      = (state_r == IDLE);
  assign out_valid                     = (state_r == DONE);
  assign {A_greater, A_equal, A_less}  = res_r;
  assign chunks_used                   = cnt_r;

endmodule

// File: tb/tb_seq_mag_comparator.sv
// Directed testbench for seq_mag_comparator at WIDTH=16, CHUNK=4.
module tb_seq_mag_comparator;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] A;
  logic [15:0] B;
  logic        signed_mode;
  logic        out_valid;
  logic        out_ready;
  logic        A_greater;
  logic        A_equal;
  logic        A_less;
  logic [2:0]  chunks_used;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_mag_comparator #(.WIDTH(16), .CHUNK(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .A           (A),
    .B           (B),
    .signed_mode (signed_mode),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .A_greater   (A_greater),
    .A_equal     (A_equal),
    .A_less      (A_less),
    .chunks_used (chunks_used)
  );

  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic s);
    A = a; B = b; signed_mode = s; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; A = ~a; B = ~b; signed_mode = ~s;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic take_result();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({in_ready, out_valid, A_greater, A_equal, A_less, chunks_used} !== 8'b1000_0000) begin
      errors++;
      $display("FAIL reset_state got rdy=%b vld=%b flags=%b%b%b cnt=%0d want rdy=1 vld=0 flags=000 cnt=0",
               in_ready, out_valid, A_greater, A_equal, A_less, chunks_used);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_equal();
    int lat;
    send(16'h1234, 16'h1234, 1'b0);
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL eq_busy in_ready=%b want 0", in_ready);
    end
    wait_done(lat);
    checks++;
    if (lat !== 4) begin
      errors++; $display("FAIL eq_latency got %0d want 4", lat);
    end
    checks++;
    if ({A_greater, A_equal, A_less} !== 3'b010 || chunks_used !== 3'd4) begin
      errors++; $display("FAIL eq_result flags=%b%b%b cnt=%0d want 010 cnt=4", A_greater, A_equal, A_less, chunks_used);
    end
    take_result();
    checks++;
    if ({in_ready, out_valid, A_greater, A_equal, A_less} !== 5'b10000) begin
      errors++; $display("FAIL eq_idle rdy=%b vld=%b flags=%b%b%b want 1 0 000", in_ready, out_valid, A_greater, A_equal, A_less);
    end
  endtask

  task automatic test_top_chunk();
    int lat;
    send(16'h8000, 16'h7FFF, 1'b0);
    wait_done(lat);
    checks++;
    if ({A_greater, A_equal, A_less} !== 3'b100 || chunks_used !== 3'd1 || lat !== 1) begin
      errors++; $display("FAIL top_unsigned flags=%b%b%b cnt=%0d lat=%0d want 100 cnt=1 lat=1", A_greater, A_equal, A_less, chunks_used, lat);
    end
    take_result();
    send(16'h8000, 16'h7FFF, 1'b1);
    wait_done(lat);
    checks++;
    if ({A_greater, A_equal, A_less} !== 3'b001 || chunks_used !== 3'd1 || lat !== 1) begin
      errors++; $display("FAIL top_signed flags=%b%b%b cnt=%0d lat=%0d want 001 cnt=1 lat=1", A_greater, A_equal, A_less, chunks_used, lat);
    end
    take_result();
    send(16'hFFFF, 16'h0001, 1'b1);
    wait_done(lat);
    checks++;
    if ({A_greater, A_equal, A_less} !== 3'b001 || chunks_used !== 3'd1) begin
      errors++; $display("FAIL neg_signed flags=%b%b%b cnt=%0d want 001 cnt=1", A_greater, A_equal, A_less, chunks_used);
    end
    take_result();
  endtask

  task automatic test_lower_chunks();
    int lat;
    send(16'h12A4, 16'h12B4, 1'b0);
    wait_done(lat);
    checks++;
    if ({A_greater, A_equal, A_less} !== 3'b001 || chunks_used !== 3'd3 || lat !== 3) begin
      errors++; $display("FAIL mid_less flags=%b%b%b cnt=%0d lat=%0d want 001 cnt=3 lat=3", A_greater, A_equal, A_less, chunks_used, lat);
    end
    take_result();
    // Lower chunk with its MSB set must compare unsigned even in signed mode
    send(16'h0800, 16'h0100, 1'b1);
    wait_done(lat);
    checks++;
    if ({A_greater, A_equal, A_less} !== 3'b100 || chunks_used !== 3'd2) begin
      errors++; $display("FAIL low_unsigned flags=%b%b%b cnt=%0d want 100 cnt=2", A_greater, A_equal, A_less, chunks_used);
    end
    take_result();
    send(16'hF0F5, 16'hF0F3, 1'b1);
    wait_done(lat);
    checks++;
    if ({A_greater, A_equal, A_less} !== 3'b100 || chunks_used !== 3'd4 || lat !== 4) begin
      errors++; $display("FAIL last_chunk flags=%b%b%b cnt=%0d lat=%0d want 100 cnt=4 lat=4", A_greater, A_equal, A_less, chunks_used, lat);
    end
    take_result();
  endtask

  task automatic test_hold();
    int lat;
    send(16'h12A4, 16'h12B4, 1'b0);
    wait_done(lat);
    for (int i = 0; i < 5; i++) begin
      A = 16'h0000; B = 16'hFFFF; signed_mode = 1'b0; in_valid = (i % 2 == 0);
      @(posedge clk); #1;
      checks++;
      if ({out_valid, in_ready, A_greater, A_equal, A_less} !== 5'b10001 || chunks_used !== 3'd3) begin
        errors++; $display("FAIL hold_%0d vld=%b rdy=%b flags=%b%b%b cnt=%0d want 1 0 001 cnt=3",
                           i, out_valid, in_ready, A_greater, A_equal, A_less, chunks_used);
      end
    end
    in_valid = 1'b0;
    take_result();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL hold_no_extra vld=%b rdy=%b want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_abort();
    bit seen = 1'b0;
    send(16'h1234, 16'h1234, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    checks++;
    if ({in_ready, out_valid, A_greater, A_equal, A_less, chunks_used} !== 8'b1000_0000) begin
      errors++; $display("FAIL abort_during rdy=%b vld=%b flags=%b%b%b cnt=%0d want 1 0 000 0",
                         in_ready, out_valid, A_greater, A_equal, A_less, chunks_used);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1 || chunks_used !== 3'd0) begin
      errors++; $display("FAIL abort_release rdy=%b cnt=%0d want 1 0", in_ready, chunks_used);
    end
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++; $display("FAIL abort_no_result out_valid seen=1 want 0");
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    out_ready = 1'b1;
    send(16'h8000, 16'h7FFF, 1'b0);
    wait_done(lat);
    checks++;
    if ({A_greater, A_equal, A_less} !== 3'b100 || chunks_used !== 3'd1) begin
      errors++; $display("FAIL b2b_first flags=%b%b%b cnt=%0d want 100 cnt=1", A_greater, A_equal, A_less, chunks_used);
    end
    A = 16'h1234; B = 16'h1234; signed_mode = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL b2b_gap rdy=%b vld=%b want 1 0", in_ready, out_valid);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL b2b_accept rdy=%b want 0", in_ready);
    end
    wait_done(lat);
    checks++;
    if ({A_greater, A_equal, A_less} !== 3'b010 || chunks_used !== 3'd4 || lat !== 4) begin
      errors++; $display("FAIL b2b_second flags=%b%b%b cnt=%0d lat=%0d want 010 cnt=4 lat=4", A_greater, A_equal, A_less, chunks_used, lat);
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    A = 16'h0000; B = 16'h0000; signed_mode = 1'b0;
    test_reset();
    test_equal();
    test_top_chunk();
    test_lower_chunks();
    test_hold();
    test_reset_abort();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
